fp_addsub_seq: RTL

Multi-cycle sequencer that performs IEEE-754 single-precision add/subtract on packed 32-bit operands. It unpacks the operands, orders and aligns the significands, and drives one shared 24-bit ripple adder/subtractor (`AdderSubtractor_24bit`) for the significand operation. It then normalizes iteratively and packs the result. It sits in the IEEE ALU between the operand registers and the result writeback, using a valid/ready handshake on both sides.

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_addsub_seq_adder.sv | 28 ++
 rtl/fp_addsub_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 add/subtract sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int SIG_W    = MAN_W + 1;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_DONE
  } fp_state_t;

endpackage

// File: rtl/fp_addsub_seq_adder.sv
// 24-bit ripple-carry adder/subtractor (AdderSubtractor_24bit) for significands.
// Latency: combinational.
// Backpressure: none; pure datapath.
// Ports: i_reg1/i_reg2 operands, i_op 0=add 1=subtract (i_reg1-i_reg2),
//        o_result sum/difference, o_cout carry out of the top bit.
module AdderSubtractor_24bit (
  input  logic [23:0] i_reg1,
  input  logic [23:0] i_reg2,
  input  logic        i_op,
  output logic [23:0] o_result,
  output logic        o_cout
);

  // Subtract is reg1 + ~reg2 + 1: invert B and inject the +1 as carry-in.
  logic [24:0] w_carry;
  logic [23:0] w_b;

  assign w_carry[0] = i_op;

  for (genvar i = 0; i < 24; i++) begin : g_bit
    assign w_b[i]        = i_reg2[i] ^ i_op;
    assign o_result[i]   = i_reg1[i] ^ w_b[i] ^ w_carry[i];
    assign w_carry[i+1]  = (i_reg1[i] & w_b[i]) | (w_carry[i] & (i_reg1[i] ^ w_b[i]));
  end

  assign o_cout = w_carry[24];

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 binary32 add/subtract, truncating, shared 24-bit adder.
// Latency: 3+k cycles accept->out_valid (k = normalize left shifts); 1 for special inputs.
// Backpressure: one op in flight; in_ready only in IDLE; result held until out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, op (0=A+B, 1=A-B);
//        out_valid/out_ready with result.
// Optional feature: define FP_SPECIAL_EN for Inf/NaN handling (bypass straight to DONE).
module fp_addsub_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  fp_state_t          r_state;
  logic               r_sign;
  logic               r_es;
  logic [EXP_W-1:0]   r_exp_x;
  logic [EXP_W-1:0]   r_exp_y;
  logic [SIG_W-1:0]   r_sig_x;
  logic [SIG_W-1:0]   r_sig_y;
  logic               r_out_valid;
  logic [31:0]        r_result;

  // Unpack; exponent 0 is flushed to a zero significand.
  logic [EXP_W-1:0]   w_ea, w_eb;
  logic [SIG_W-1:0]   w_siga, w_sigb;
  logic               w_sb_eff, w_es, w_a_ge;

  assign w_ea     = a[30:23];
  assign w_eb     = b[30:23];
  assign w_siga   = (w_ea == '0) ? '0 : {1'b1, a[22:0]};
  assign w_sigb   = (w_eb == '0) ? '0 : {1'b1, b[22:0]};
  assign w_sb_eff = b[31] ^ op;
  assign w_es     = a[31] ^ w_sb_eff;
  assign w_a_ge   = {w_ea, w_siga} >= {w_eb, w_sigb};

`ifdef FP_SPECIAL_EN
  logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special;
  logic [31:0] w_special_res;

  assign w_a_inf   = (w_ea == EXP_W'(EXP_MAX)) && (a[22:0] == '0);
  assign w_b_inf   = (w_eb == EXP_W'(EXP_MAX)) && (b[22:0] == '0);
  assign w_a_nan   = (w_ea == EXP_W'(EXP_MAX)) && (a[22:0] != '0);
  assign w_b_nan   = (w_eb == EXP_W'(EXP_MAX)) && (b[22:0] != '0);
  assign w_special = (w_ea == EXP_W'(EXP_MAX)) || (w_eb == EXP_W'(EXP_MAX));
  assign w_special_res = (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_es)) ? QNAN :
                         w_a_inf ? {a[31], 8'hFF, 23'h0} : {w_sb_eff, 8'hFF, 23'h0};
`endif

  // Alignment distance; anything past the significand width shifts Y out entirely.
  logic [EXP_W-1:0] w_shamt;
  logic [SIG_W-1:0] w_sig_y_sh;

  assign w_shamt    = r_exp_x - r_exp_y;
  assign w_sig_y_sh = (w_shamt >= EXP_W'(SIG_W)) ? '0 : (r_sig_y >> w_shamt);

  logic [SIG_W-1:0] w_sum;
  logic             w_cout;

  AdderSubtractor_24bit u_addsub (
    .i_reg1   (r_sig_x),
    .i_reg2   (r_sig_y),
    .i_op     (r_es),
    .o_result (w_sum),
    .o_cout   (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sign      <= 1'b0;
      r_es        <= 1'b0;
      r_exp_x     <= '0;
      r_exp_y     <= '0;
      r_sig_x     <= '0;
      r_sig_y     <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_es    <= w_es;
            r_sign  <= w_a_ge ? a[31]  : w_sb_eff;
            r_exp_x <= w_a_ge ? w_ea   : w_eb;
            r_exp_y <= w_a_ge ? w_eb   : w_ea;
            r_sig_x <= w_a_ge ? w_siga : w_sigb;
            r_sig_y <= w_a_ge ? w_sigb : w_siga;
`ifdef FP_SPECIAL_EN
            if (w_special) begin
              r_result    <= w_special_res;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_ALIGN;
            end
`else
            r_state <= ST_ALIGN;
`endif
          end
        end
        ST_ALIGN: begin
          r_sig_y <= w_sig_y_sh;
          r_state <= ST_ADD;
        end
        ST_ADD: begin
          // Carry out on an effective add: renormalize right by one, dropping the LSB.
          if (!r_es && w_cout) begin
            r_sig_x <= {1'b1, w_sum[SIG_W-1:1]};
            r_exp_x <= r_exp_x + 1'b1;
          end else begin
            r_sig_x <= w_sum;
          end
          r_state <= ST_NORM;
        end
        ST_NORM: begin
          if (r_exp_x == EXP_W'(EXP_MAX)) begin
            r_result    <= {r_sign, 8'hFF, 23'h0};
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (r_sig_x == '0) begin
            r_result    <= '0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (!r_sig_x[SIG_W-1] && (r_exp_x > EXP_W'(1))) begin
            r_sig_x <= {r_sig_x[SIG_W-2:0], 1'b0};
            r_exp_x <= r_exp_x - 1'b1;
          end else if (!r_sig_x[SIG_W-1] && (r_exp_x == EXP_W'(1))) begin
            r_result    <= {r_sign, 31'h0};
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_result    <= {r_sign, r_exp_x, r_sig_x[MAN_W-1:0]};
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

endmodule
